// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the receiver and its TX successor.
//   PARITY_* : parity mode encodings
//   rx_state_e : receiver FSM states
//   cpb()    : rounded clocks-per-bit from clock and line rate
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  function automatic int unsigned cpb(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receiver output bus (word + valid/ready handshake + status).
//   rx_data/rx_valid/parity_err : word and sideband, held until accepted
//   rx_ready                    : consumer accept
//   frame_err/overrun           : single-cycle event pulses
//   rx_busy                     : frame in progress
// master = receiver, slave = consumer.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;

  modport master (output rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, parity_err, frame_err, overrun, rx_busy,
                  output rx_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the async RXD pin plus a falling-edge strobe.
//   clk, rst : clock, synchronous active-high reset (flops reset to line idle = 1)
//   rxd      : asynchronous serial input
//   rxs      : synchronised line
//   fall_c   : high for one cycle when rxs goes 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxs,
  output logic fall_c
);

  logic s1_q, s2_q, s3_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rxd;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rxs    = s2_q;
  assign fall_c = s3_q & ~s2_q;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling,
// false-start rejection, parity/framing/overrun reporting and valid/ready output.
//   clk, rst : clock, synchronous active-high reset
//   rxd      : asynchronous serial line, idle high
//   bus      : output word interface (master side)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 65_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PARITY_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  uart_rx_param_if.master bus
);

  localparam int unsigned CPB = cpb(CLK_HZ, BAUD);
  localparam int unsigned PW  = $clog2(CPB);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  localparam logic [PW-1:0] PH_A     = PW'(CPB / 2 - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(CPB / 2);
  localparam logic [PW-1:0] PH_D     = PW'(CPB / 2 + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STP_LAST = BW'(STOP_BITS - 1);

  logic rxs, fall_c;

  rx_state_e            state_q, state_d;
  logic [PW-1:0]        phase_q;
  logic [BW-1:0]        bit_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q;

  logic decide_c, maj_c, par_x_c, par_bad_c;
  logic phase_clr, bit_clr, bit_inc, shift_en, par_en, deliver, ferr;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .rxs    (rxs),
    .fall_c (fall_c)
  );

  // The vote completes on the third sample, so the bit decision is taken at CPB/2+1.
  assign decide_c  = (phase_q == PH_D);
  assign maj_c     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign par_x_c   = (^shreg_q) ^ maj_c;
  assign par_bad_c = (PARITY == PARITY_ODD)  ? ~par_x_c :
                     (PARITY == PARITY_EVEN) ?  par_x_c : 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d   = state_q;
    phase_clr = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    deliver   = 1'b0;
    ferr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d   = ST_START;
          phase_clr = 1'b1;
          bit_clr   = 1'b1;
        end
      end
      ST_START: begin
        if (decide_c) state_d = maj_c ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide_c) begin
          shift_en = 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_clr = 1'b1;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (decide_c) begin
          par_en  = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide_c) begin
          if (!maj_c) begin
            ferr      = 1'b1;
            phase_clr = 1'b1;
            state_d   = ST_BREAK;
          end else if (bit_q == STP_LAST) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Phase counter doubles as the high-time counter: any low restarts it.
        if (!rxs)                        phase_clr = 1'b1;
        else if (phase_q == PH_LAST)     state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase/bit counters, vote samples, shift register, parity flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (phase_clr || phase_q == PH_LAST) phase_q <= '0;
      else                                 phase_q <= phase_q + PW'(1);
      if (bit_clr)      bit_q <= '0;
      else if (bit_inc) bit_q <= bit_q + BW'(1);
      if (phase_q == PH_A)   samp_q[0] <= rxs;
      if (phase_q == PH_MID) samp_q[1] <= rxs;
      if (shift_en) shreg_q <= {maj_c, shreg_q[DATA_BITS-1:1]};
      if (state_q == ST_IDLE) perr_q <= 1'b0;
      else if (par_en)        perr_q <= par_bad_c;
    end
  end

  // Output register: word load or overrun, handshake, event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.rx_busy    <= 1'b0;
    end else begin
      bus.frame_err <= ferr;
      bus.overrun   <= 1'b0;
      bus.rx_busy   <= (state_d != ST_IDLE);
      if (deliver) begin
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_data    <= shreg_q;
          bus.parity_err <= perr_q;
          bus.rx_valid   <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param.
// Three receivers: A = 8N1 CPB=10, B = 8E1 CPB=10, C = 7O2 CPB=13.
module tb_uart_rx_param;
  import uart_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;
  logic rxd_c = 1'b1;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_param_if #(.DATA_BITS(8)) bus_b ();
  uart_rx_param_if #(.DATA_BITS(7)) bus_c ();

  uart_rx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(PARITY_NONE), .STOP_BITS(1))
    u_a (.clk(clk), .rst(rst), .rxd(rxd_a), .bus(bus_a));
  uart_rx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(PARITY_EVEN), .STOP_BITS(1))
    u_b (.clk(clk), .rst(rst), .rxd(rxd_b), .bus(bus_b));
  uart_rx_param #(.CLK_HZ(1_300_000), .BAUD(100_000), .DATA_BITS(7),
                  .PARITY(PARITY_ODD), .STOP_BITS(2))
    u_c (.clk(clk), .rst(rst), .rxd(rxd_c), .bus(bus_c));

  // Event monitors, sampled on the falling edge.
  int acc_a = 0, fe_a = 0, ov_a = 0, vhi_a = 0;
  int acc_b = 0, acc_c = 0, fe_c = 0;
  logic [7:0] dat_a = '0, dat_b = '0;
  logic [6:0] dat_c = '0;
  logic       perr_a = 1'b0, perr_b = 1'b0, perr_c = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.rx_valid && bus_a.rx_ready) begin
        acc_a  <= acc_a + 1;
        dat_a  <= bus_a.rx_data;
        perr_a <= bus_a.parity_err;
      end
      if (bus_a.frame_err) fe_a  <= fe_a + 1;
      if (bus_a.overrun)   ov_a  <= ov_a + 1;
      if (bus_a.rx_valid)  vhi_a <= vhi_a + 1;
      if (bus_b.rx_valid && bus_b.rx_ready) begin
        acc_b  <= acc_b + 1;
        dat_b  <= bus_b.rx_data;
        perr_b <= bus_b.parity_err;
      end
      if (bus_c.rx_valid && bus_c.rx_ready) begin
        acc_c  <= acc_c + 1;
        dat_c  <= bus_c.rx_data;
        perr_c <= bus_c.parity_err;
      end
      if (bus_c.frame_err) fe_c <= fe_c + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ln, input logic v, input int n);
    case (ln)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
    repeat (n) tick();
  endtask

  // Start, nb data bits LSB first (optional one-clock spike mid bit 'spike'),
  // optional parity bit pb, ns stop bits with the first one set to sv.
  task automatic send(input int ln, input logic [7:0] d, input int nb, input bit has_par,
                      input logic pb, input int ns, input logic sv, input int cpb_n,
                      input int spike);
    put(ln, 1'b0, cpb_n);
    for (int i = 0; i < nb; i++) begin
      if (i == spike) begin
        put(ln, d[i], 7);
        put(ln, ~d[i], 1);
        put(ln, d[i], cpb_n - 8);
      end else begin
        put(ln, d[i], cpb_n);
      end
    end
    if (has_par) put(ln, pb, cpb_n);
    for (int i = 0; i < ns; i++) put(ln, (i == 0) ? sv : 1'b1, cpb_n);
  endtask

  int a0, f0, o0, v0, b0, c0;

  initial begin
    bus_a.rx_ready = 1'b1;
    bus_b.rx_ready = 1'b1;
    bus_c.rx_ready = 1'b1;
    repeat (3) tick();
    check("reset_valid", 32'(bus_a.rx_valid), 32'd0);
    check("reset_data",  32'(bus_a.rx_data), 32'd0);
    check("reset_busy",  32'(bus_a.rx_busy), 32'd0);
    check("reset_flags", 32'({bus_a.parity_err, bus_a.frame_err, bus_a.overrun}), 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // 8N1 0xA5 with consumer ready
    a0 = acc_a; f0 = fe_a; v0 = vhi_a;
    send(0, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 10, -1);
    put(0, 1'b1, 6);
    check("8n1_count",  32'(acc_a - a0), 32'd1);
    check("8n1_data",   32'(dat_a), 32'hA5);
    check("8n1_perr",   32'(perr_a), 32'd0);
    check("8n1_vwidth", 32'(vhi_a - v0), 32'd1);
    check("8n1_ferr",   32'(fe_a - f0), 32'd0);

    // 8E1 0x3C: parity bit 1 is wrong for even parity, 0 is right
    b0 = acc_b;
    send(1, 8'h3C, 8, 1'b1, 1'b1, 1, 1'b1, 10, -1);
    put(1, 1'b1, 6);
    check("8e1_bad_count", 32'(acc_b - b0), 32'd1);
    check("8e1_bad_data",  32'(dat_b), 32'h3C);
    check("8e1_bad_perr",  32'(perr_b), 32'd1);
    send(1, 8'h3C, 8, 1'b1, 1'b0, 1, 1'b1, 10, -1);
    put(1, 1'b1, 6);
    check("8e1_ok_count", 32'(acc_b - b0), 32'd2);
    check("8e1_ok_perr",  32'(perr_b), 32'd0);

    // Short start glitch: busy briefly, then rejected silently
    a0 = acc_a; f0 = fe_a;
    put(0, 1'b0, 3);
    check("glitch_busy_on", 32'(bus_a.rx_busy), 32'd1);
    put(0, 1'b1, 8);
    check("glitch_busy_off", 32'(bus_a.rx_busy), 32'd0);
    put(0, 1'b1, 20);
    check("glitch_no_word", 32'(acc_a - a0), 32'd0);
    check("glitch_no_ferr", 32'(fe_a - f0), 32'd0);

    // Stop bit low then line held low: one frame error, wait for idle line
    a0 = acc_a; f0 = fe_a;
    send(0, 8'h55, 8, 1'b0, 1'b0, 1, 1'b0, 10, -1);
    put(0, 1'b0, 30);
    check("break_ferr_once", 32'(fe_a - f0), 32'd1);
    check("break_busy_low",  32'(bus_a.rx_busy), 32'd1);
    put(0, 1'b1, 16);
    check("break_busy_idle", 32'(bus_a.rx_busy), 32'd0);
    check("break_no_word",   32'(acc_a - a0), 32'd0);
    check("break_ferr_tot",  32'(fe_a - f0), 32'd1);
    send(0, 8'h0F, 8, 1'b0, 1'b0, 1, 1'b1, 10, -1);
    put(0, 1'b1, 6);
    check("break_recover_cnt",  32'(acc_a - a0), 32'd1);
    check("break_recover_data", 32'(dat_a), 32'h0F);

    // Overrun: two words with consumer stalled
    bus_a.rx_ready = 1'b0;
    a0 = acc_a; o0 = ov_a;
    send(0, 8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 10, -1);
    put(0, 1'b1, 4);
    check("ovr_first_ovr", 32'(ov_a - o0), 32'd0);
    send(0, 8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 10, -1);
    put(0, 1'b1, 6);
    check("ovr_valid_held", 32'(bus_a.rx_valid), 32'd1);
    check("ovr_data_held",  32'(bus_a.rx_data), 32'h11);
    check("ovr_pulse",      32'(ov_a - o0), 32'd1);
    check("ovr_no_accept",  32'(acc_a - a0), 32'd0);
    bus_a.rx_ready = 1'b1;
    tick();
    tick();
    check("ovr_accept_cnt",  32'(acc_a - a0), 32'd1);
    check("ovr_accept_data", 32'(dat_a), 32'h11);
    check("ovr_valid_clr",   32'(bus_a.rx_valid), 32'd0);

    // 7O2 CPB=13: 0x2B has four ones, odd parity bit = 1; spike on data bit 2
    c0 = acc_c;
    send(2, 8'h2B, 7, 1'b1, 1'b1, 2, 1'b1, 13, 2);
    put(2, 1'b1, 6);
    check("7o2_count", 32'(acc_c - c0), 32'd1);
    check("7o2_data",  32'(dat_c), 32'h2B);
    check("7o2_perr",  32'(perr_c), 32'd0);
    check("7o2_ferr",  32'(fe_c), 32'd0);
    send(2, 8'h2B, 7, 1'b1, 1'b0, 2, 1'b1, 13, 3);
    put(2, 1'b1, 6);
    check("7o2_bad_count", 32'(acc_c - c0), 32'd2);
    check("7o2_bad_data",  32'(dat_c), 32'h2B);
    check("7o2_bad_perr",  32'(perr_c), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
